// File: rtl/refr_sched_mrnrwpw_1rw_mt.sv
// Refresh scheduler and request gate in front of a multi-port 1RW-macro memory.
// Banks refresh obligations as credits, issues them in idle cycles, and forces one when the bank fills.
module refr_sched_mrnrwpw_1rw_mt #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13,
  parameter int NUMPORT = 4,
  parameter int REFPER  = 64,
  parameter int BITREFP = 6,
  parameter int MAXPOST = 8,
  parameter int BITPOST = 4,
  parameter int ENABLE  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic [NUMPORT-1:0]         cli_read,
  input  logic [NUMPORT-1:0]         cli_write,
  input  logic [NUMPORT*BITADDR-1:0] cli_addr,
  input  logic [NUMPORT*WIDTH-1:0]   cli_din,
  output logic                       cli_stall,
  output logic                       refr,
  output logic [NUMPORT-1:0]         read,
  output logic [NUMPORT-1:0]         write,
  output logic [NUMPORT*BITADDR-1:0] addr,
  output logic [NUMPORT*WIDTH-1:0]   din,
  output logic [BITPOST-1:0]         pend
);

  typedef enum logic {NORM = 1'b0, FORCE = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [BITREFP-1:0] tmr;
  logic [BITPOST-1:0] pend_nxt;
  logic               act, tick, busy, accept, opp, frc, issue;

  assign act       = ready && !rst;
  assign tick      = act && (ENABLE != 0) && (tmr == BITREFP'(REFPER - 1));
  assign busy      = |(cli_read | cli_write);
  assign accept    = act && (state == NORM);
  assign opp       = accept && (pend != '0) && !busy;
  assign frc       = (state == FORCE);
  assign issue     = opp || frc;
  assign cli_stall = !ready || frc;

  // A tick and an issue in the same cycle cancel; the bank can only fill via the forced path.
  always_comb begin
    state_nxt = NORM;
    pend_nxt  = '0;
    if (act) begin
      pend_nxt = pend + BITPOST'(tick) - BITPOST'(issue);
      if ((state == NORM) && tick && !issue && (pend == BITPOST'(MAXPOST - 1)))
        state_nxt = FORCE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= NORM;
    else     state <= state_nxt;
  end

  // Output register stage: one cycle of latency on every memory-side signal.
  always_ff @(posedge clk) begin
    if (!act) begin
      tmr   <= '0;
      pend  <= '0;
      refr  <= 1'b0;
      read  <= '0;
      write <= '0;
      addr  <= '0;
      din   <= '0;
    end else begin
      tmr  <= tick ? '0 : tmr + BITREFP'(1);
      pend <= pend_nxt;
      refr <= issue;
      if (accept) begin
        read  <= cli_read;
        write <= cli_write;
        addr  <= cli_addr;
        din   <= cli_din;
      end else begin
        read  <= '0;
        write <= '0;
      end
    end
  end

endmodule
